i2s_rx: RTL and testbench

- Receives a serial I2S-style audio stream: bit clock, word select, data.
- Deserialises it into parallel 16-bit left/right samples with a one-cycle strobe in the system clock domain.
- It is the receive end of the headphone audio link format used by the video/audio output path. It serves the external audio-input option and the loopback bench for the audio transmitter.
- Sits between the pad-level I2S inputs and the core audio mixer.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/sync2.sv | 29 ++
 rtl/i2s_rx.sv | 169 ++++++++++++++++
 tb/tb_i2s_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-link definitions: sample width, frame size, receiver states.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Offset binary to two's complement is a flip of the sign bit.
  function automatic logic [SAMPLE_W-1:0] conv_sample(input logic [SAMPLE_W-1:0] x,
                                                      input logic               offset_bin);
    conv_sample = offset_bin ? (x ^ {1'b1, {(SAMPLE_W-1){1'b0}}}) : x;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a small bundle of asynchronous single-bit inputs.
// Latency: 2 clk.
// Backpressure: none; free-running every clk.
module sync2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Plain two-stage metastability filter, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver producing 16-bit L/R samples.
// Latency: strobe 4 clk after the BCK pin edge carrying the last right bit.
// Backpressure: none; the mixer must take each strobe, samples hold until the next.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int WS_DELAY      = 0,
  parameter int OFFSET_BINARY = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bck,
  input  logic                i2s_ws,
  input  logic                i2s_din,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                sample_strobe,
  output logic                locked,
  output logic                frame_err
);

  localparam logic [7:0] TO_MAX   = 8'(TIMEOUT);
  localparam logic       CONV_EN  = (OFFSET_BINARY != 0);
  localparam logic       DELAYED  = (WS_DELAY != 0);
  localparam logic [4:0] LAST_BIT = 5'(SAMPLE_W - 1);
  localparam logic [4:0] CNT_SAT  = 5'd31;

  logic [2:0]          sync_s2;
  logic                bck_s2, ws_s2, din_s2;
  logic                rise, edge_ok;
  logic [SAMPLE_W-1:0] word;

  logic                bck_s3_q, ws_prev_q, ws_prev_d;
  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [7:0]          to_cnt_q, to_cnt_d;
  logic                locked_q, locked_d;
  logic                upd_q, upd_d;
  logic                err_q, err_d;
  logic                strobe_q, strobe_d;
  logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
  logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
  logic                go;

  sync2 #(.W(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   ({i2s_bck, i2s_ws, i2s_din}),
    .q_o   (sync_s2)
  );

  assign bck_s2 = sync_s2[2];
  assign ws_s2  = sync_s2[1];
  assign din_s2 = sync_s2[0];
  assign rise   = bck_s2 & ~bck_s3_q;
  // Any WS change starts a new half, except that HUNT only accepts the start of a left half.
  assign edge_ok = rise & (ws_s2 != ws_prev_q) & ((state_q != HUNT) | ~ws_s2);
  assign word   = {sh_q[SAMPLE_W-2:0], din_s2};

  // Protocol next-state: half tracking, bit capture, lock, timeout and output update.
  always_comb begin
    ws_prev_d  = ws_prev_q;
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    hold_l_d   = hold_l_q;
    to_cnt_d   = to_cnt_q;
    locked_d   = locked_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    strobe_d   = upd_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    go         = 1'b0;

    if (rise) begin
      ws_prev_d = ws_s2;
      to_cnt_d  = 8'd0;
      // Philips format starts the half one BCK after the WS edge; the edge rise
      // itself still carries the previous half's last bit.
      if (DELAYED) begin
        go     = pend_q;
        pend_d = edge_ok & ~pend_q;
      end else begin
        go     = edge_ok;
      end

      if (go) begin
        if ((state_q != HUNT) && (cnt_q <= LAST_BIT)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
        state_d = (state_q == LEFT) ? RIGHT : LEFT;
        cnt_d   = 5'd1;
        sh_d    = {{(SAMPLE_W-1){1'b0}}, din_s2};
      end else if (state_q != HUNT) begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        if (cnt_q <= LAST_BIT) sh_d = word;
        if (cnt_q == LAST_BIT) begin
          if (state_q == LEFT) begin
            hold_l_d = word;
            locked_d = 1'b1;
          end else begin
            upd_d = locked_q;
          end
        end
      end
    end else if (to_cnt_q == TO_MAX) begin
      state_d  = HUNT;
      pend_d   = 1'b0;
      locked_d = 1'b0;
    end else begin
      to_cnt_d = to_cnt_q + 8'd1;
    end

    // Rises are never back to back, so sh_q still holds the right word here.
    if (upd_q) begin
      sample_l_d = conv_sample(hold_l_q, CONV_EN);
      sample_r_d = conv_sample(sh_q, CONV_EN);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bck_s3_q   <= 1'b0;
      ws_prev_q  <= 1'b0;
      state_q    <= HUNT;
      pend_q     <= 1'b0;
      cnt_q      <= 5'd0;
      sh_q       <= '0;
      hold_l_q   <= '0;
      to_cnt_q   <= 8'd0;
      locked_q   <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      strobe_q   <= 1'b0;
      sample_l_q <= '0;
      sample_r_q <= '0;
    end else begin
      bck_s3_q   <= bck_s2;
      ws_prev_q  <= ws_prev_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      hold_l_q   <= hold_l_d;
      to_cnt_q   <= to_cnt_d;
      locked_q   <= locked_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      strobe_q   <= strobe_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
    end
  end

  assign sample_l      = sample_l_q;
  assign sample_r      = sample_r_q;
  assign sample_strobe = strobe_q;
  assign locked        = locked_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: three builds share one serial stream.
// u_dut0 = left-justified/offset-binary, u_dut1 = Philips/raw, u_dut2 = left-justified/raw.
module tb_i2s_rx;

  localparam int HALF      = 20;
  localparam int FRAME_CLK = 64 * HALF;

  logic clk = 1'b0;
  logic reset, bck, ws, din;

  logic [15:0] l0, r0, l1, r1, l2, r2;
  logic        s0, k0, e0, s1, k1, e1, s2, k2, e2;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int last_rise_cyc = 0;
  int n_strobe = 0, n_strobe1 = 0, n_ferr = 0, n_long = 0;
  int last_strobe_cyc = 0, prev_strobe_cyc = 0, strobe_lat = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;
  logic ph_prev = 1'b0;
  int base, base1, rise_ref;

  i2s_rx #(.WS_DELAY(0), .OFFSET_BINARY(1), .TIMEOUT(255)) u_dut0 (
    .clk(clk), .reset(reset), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
    .sample_l(l0), .sample_r(r0), .sample_strobe(s0), .locked(k0), .frame_err(e0));

  i2s_rx #(.WS_DELAY(1), .OFFSET_BINARY(0), .TIMEOUT(255)) u_dut1 (
    .clk(clk), .reset(reset), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
    .sample_l(l1), .sample_r(r1), .sample_strobe(s1), .locked(k1), .frame_err(e1));

  i2s_rx #(.WS_DELAY(0), .OFFSET_BINARY(0), .TIMEOUT(255)) u_dut2 (
    .clk(clk), .reset(reset), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
    .sample_l(l2), .sample_r(r2), .sample_strobe(s2), .locked(k2), .frame_err(e2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor on the falling edge; the stimulus moves 1 time unit later.
  always @(negedge clk) begin
    if (s0) begin
      n_strobe        = n_strobe + 1;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_lat      = cyc - last_rise_cyc;
    end
    if (e0) n_ferr = n_ferr + 1;
    if ((s0 && prev_s) || (e0 && prev_e)) n_long = n_long + 1;
    prev_s = s0;
    prev_e = e0;
    if (s1) n_strobe1 = n_strobe1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One BCK period: data/WS change with BCK low, sampled on the rising edge.
  task automatic slot(input logic w, input logic d);
    bck = 1'b0;
    ws  = w;
    din = d;
    tick(HALF);
    bck = 1'b1;
    last_rise_cyc = cyc;
    tick(HALF);
  endtask

  // Left-justified frame; nleft < 16 truncates the left half.
  task automatic frame_lj(input logic [15:0] l, input logic [15:0] r, input int nleft);
    for (int k = 0; k < nleft; k++) slot(1'b0, l[15-k]);
    for (int k = 0; k < 16; k++) slot(1'b1, r[15-k]);
  endtask

  // Philips frame: each word's MSB one BCK after the WS edge, LSB on the next edge.
  task automatic frame_ph(input logic [15:0] l, input logic [15:0] r);
    for (int k = 0; k < 32; k++) begin
      if (k == 0)       slot(1'b0, ph_prev);
      else if (k <= 16) slot(k >= 16, l[16-k]);
      else              slot(1'b1, r[32-k]);
    end
    ph_prev = r[0];
  endtask

  task automatic idle_bck();
    bck = 1'b0;
    tick(300);
  endtask

  initial begin
    reset = 1'b1;
    bck   = 1'b0;
    ws    = 1'b0;
    din   = 1'b0;
    tick(3);
    chk("rst_sample_l", 32'(l0), 32'h0);
    chk("rst_sample_r", 32'(r0), 32'h0);
    chk("rst_strobe", 32'(s0), 32'h0);
    chk("rst_locked", 32'(k0), 32'h0);
    chk("rst_frame_err", 32'(e0), 32'h0);
    reset = 1'b0;
    tick(2);

    // Frame 1 has no 1->0 WS edge after reset, so decoding starts at frame 2.
    base = n_strobe;
    frame_lj(16'h9234, 16'h9234, 16);
    chk("t1_no_strobe_f1", 32'(n_strobe - base), 32'd0);
    chk("t1_unlocked_f1", 32'(k0), 32'h0);
    frame_lj(16'h9234, 16'h9234, 16);
    chk("t1_strobe_f2", 32'(n_strobe - base), 32'd1);
    chk("t1_sample_l", 32'(l0), 32'h1234);
    chk("t1_sample_r", 32'(r0), 32'h1234);
    chk("t1_locked", 32'(k0), 32'h1);
    chk("t1_latency", 32'(strobe_lat), 32'd4);
    frame_lj(16'h9234, 16'h9234, 16);
    chk("t1_strobe_f3", 32'(n_strobe - base), 32'd2);
    chk("t1_spacing", 32'(last_strobe_cyc - prev_strobe_cyc), 32'(FRAME_CLK));

    // BCK stops: lock drops about 255 clk after the last rise, samples hold.
    rise_ref = last_rise_cyc;
    bck = 1'b0;
    tick(250 - (cyc - rise_ref));
    chk("to_still_locked", 32'(k0), 32'h1);
    tick(15);
    chk("to_unlocked", 32'(k0), 32'h0);
    chk("to_hold_l", 32'(l0), 32'h1234);
    chk("to_hold_r", 32'(r0), 32'h1234);

    // Restart; WS was left high so the first left half is caught at once.
    base = n_strobe;
    frame_lj(16'h0000, 16'hFFFF, 16);
    frame_lj(16'h0000, 16'hFFFF, 16);
    chk("t2_strobes", 32'(n_strobe - base), 32'd2);
    chk("t2_sample_l", 32'(l0), 32'h8000);
    chk("t2_sample_r", 32'(r0), 32'h7FFF);
    chk("t2_no_ferr", 32'(n_ferr), 32'd0);

    // Truncated left half.
    base = n_strobe;
    frame_lj(16'hC001, 16'h4002, 10);
    chk("t3_ferr_once", 32'(n_ferr), 32'd1);
    chk("t3_unlocked", 32'(k0), 32'h0);
    chk("t3_no_strobe", 32'(n_strobe - base), 32'd0);
    chk("t3_hold_l", 32'(l0), 32'h8000);
    frame_lj(16'hC001, 16'h4002, 16);
    chk("t3_relocked", 32'(k0), 32'h1);
    chk("t3_strobe", 32'(n_strobe - base), 32'd1);
    chk("t3_sample_l", 32'(l0), 32'h4001);
    chk("t3_sample_r", 32'(r0), 32'hC002);
    chk("t3_pulse_width", 32'(n_long), 32'd0);

    // Reset in the middle of a right half.
    idle_bck();
    frame_lj(16'h9234, 16'h9234, 16);
    chk("t6_pre_sample_l", 32'(l0), 32'h1234);
    for (int k = 0; k < 16; k++) slot(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) slot(1'b1, 1'b0);
    bck = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_sample_l", 32'(l0), 32'h0);
    chk("t6_rst_sample_r", 32'(r0), 32'h0);
    chk("t6_rst_locked", 32'(k0), 32'h0);
    chk("t6_rst_strobe", 32'(s0), 32'h0);
    reset = 1'b0;
    base = n_strobe;
    for (int k = 8; k < 16; k++) slot(1'b1, 1'b1);
    chk("t6_no_strobe_tail", 32'(n_strobe - base), 32'd0);
    frame_lj(16'hABCD, 16'h1357, 16);
    chk("t6_strobe", 32'(n_strobe - base), 32'd1);
    chk("t6_sample_l", 32'(l0), 32'h2BCD);
    chk("t6_sample_r", 32'(r0), 32'h9357);

    // Philips stream, plus one trailing slot to deliver the final right LSB.
    idle_bck();
    base1 = n_strobe1;
    ph_prev = 1'b0;
    frame_ph(16'hA5A5, 16'h5A5A);
    frame_ph(16'hA5A5, 16'h5A5A);
    slot(1'b0, ph_prev);
    chk("t5_ph_strobes", 32'(n_strobe1 - base1), 32'd2);
    chk("t5_ph_sample_l", 32'(l1), 32'hA5A5);
    chk("t5_ph_sample_r", 32'(r1), 32'h5A5A);
    chk("t5_ph_no_ferr", 32'(e1), 32'h0);
    // A left-justified build sees every word shifted by one bit.
    chk("t5_lj_sample_l", 32'(l2), 32'h52D2);
    chk("t5_lj_sample_r", 32'(r2), 32'hAD2D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
